// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode and ALUOp encodings for the multicycle MIPS control path
package mips_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational state to control-word decoder
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  cw_o
);
  always_comb begin
    cw_o = '0;
    case (state_i)
      FETCH: begin
        cw_o.alu_src_b = 2'b01;
        cw_o.ir_write  = 1'b1;
        cw_o.pc_write  = 1'b1;
      end
      DECODE: cw_o.alu_src_b = 2'b11;
      MEMADR: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = 2'b10;
      end
      MEMRD: cw_o.iord = 1'b1;
      MEMWB: begin
        cw_o.mem_to_reg = 1'b1;
        cw_o.reg_write  = 1'b1;
      end
      MEMWR: begin
        cw_o.iord      = 1'b1;
        cw_o.mem_write = 1'b1;
      end
      EXECUTE: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        cw_o.reg_dst   = 1'b1;
        cw_o.reg_write = 1'b1;
      end
      BRANCH: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_op    = ALUOP_SUB;
        cw_o.pc_src    = 2'b01;
        cw_o.branch    = 1'b1;
      end
      ADDIEXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = 2'b10;
      end
      ADDIWB: cw_o.reg_write = 1'b1;
      JUMP: begin
        cw_o.pc_src   = 2'b10;
        cw_o.pc_write = 1'b1;
      end
      default: cw_o = '0;
    endcase
  end
endmodule

// File: rtl/mips_main_fsm.sv
// mips_main_fsm: multicycle MIPS main control FSM with memory-ready handshake
module mips_main_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal,
  output logic [3:0] state
);
  state_t state_q, state_d;
  ctrl_t  cw;
  logic   is_fetch, known_op, pc_write;
  mips_ctrl_decode u_dec (.state_i(state_q), .cw_o(cw));
  assign is_fetch = state_q == FETCH;
  assign known_op = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE:   state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                          opcode == OP_RTYPE ? EXECUTE :
                          opcode == OP_BEQ   ? BRANCH :
                          opcode == OP_ADDI  ? ADDIEXEC :
                          opcode == OP_J     ? JUMP : FETCH;
      MEMADR:   state_d = opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) state_q <= rst ? FETCH : state_d;
  // fetch-time PC/IR loads wait for the memory handshake; the jump load does not
  assign pc_write   = cw.pc_write & (mem_ready | ~is_fetch);
  assign ir_write   = cw.ir_write & mem_ready & ~rst;
  assign mem_write  = cw.mem_write & ~rst;
  assign reg_write  = cw.reg_write & ~rst;
  assign pc_en      = (pc_write | (cw.branch & zero)) & ~rst;
  assign illegal    = (state_q == DECODE) & ~known_op & ~rst;
  assign iord       = cw.iord;
  assign reg_dst    = cw.reg_dst;
  assign mem_to_reg = cw.mem_to_reg;
  assign alu_src_a  = cw.alu_src_a;
  assign alu_src_b  = cw.alu_src_b;
  assign alu_op     = cw.alu_op;
  assign pc_src     = cw.pc_src;
  assign state      = state_q;
endmodule

// File: tb/tb_mips_main_fsm.sv
// tb_mips_main_fsm: per-cycle scoreboard check of the multicycle MIPS control FSM
module tb_mips_main_fsm;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [18:0] got, want;
  logic [18:0] sb[$];
  int checks = 0, failures = 0;
  typedef struct packed {
    logic       r;
    logic [5:0] op;
    logic       z;
    logic       mr;
    logic [3:0] st;
  } stim_t;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  mips_main_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;
  assign got = {state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal};

  // expected outputs for a given state and inputs, written from the state table
  function automatic logic [18:0] exp_out(logic [3:0] st, logic [5:0] op, logic z, logic mr, logic r);
    logic io = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pw = 0, br = 0, il = 0;
    logic [1:0] sbv = 0, ao = 0, ps = 0;
    case (st)
      4'd0:  begin sbv = 2'b01; irw = mr; pw = mr; end
      4'd1:  begin sbv = 2'b11; il = !(op inside {LW, SW, RT, BEQ, ADDI, J}); end
      4'd2:  begin sa = 1; sbv = 2'b10; end
      4'd3:  io = 1;
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin io = 1; mw = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      4'd9:  begin sa = 1; sbv = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {st, io, mw & !r, irw & !r, rd, m2r, rw & !r, sa, sbv, ao, ps,
            (pw | (br & z)) & !r, il & !r};
  endfunction

  task automatic test_reset();
    stim_t s[$] = '{'{1'b1, RT, 1'b1, 1'b1, 4'd0}, '{1'b1, RT, 1'b0, 1'b0, 4'd0}};
    rst = 1'b1;
    @(posedge clk); #1;
    foreach (s[i]) begin
      {rst, opcode, zero, mem_ready} = {s[i].r, s[i].op, s[i].z, s[i].mr};
      sb.push_back(exp_out(s[i].st, s[i].op, s[i].z, s[i].mr, s[i].r));
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL reset cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    stim_t s[$] = '{'{1'b0, LW, 1'b1, 1'b1, 4'd0}, '{1'b0, LW, 1'b1, 1'b1, 4'd1},
                    '{1'b0, LW, 1'b1, 1'b1, 4'd2}, '{1'b0, LW, 1'b1, 1'b1, 4'd3},
                    '{1'b0, LW, 1'b1, 1'b1, 4'd4}};
    foreach (s[i]) begin
      {rst, opcode, zero, mem_ready} = {s[i].r, s[i].op, s[i].z, s[i].mr};
      sb.push_back(exp_out(s[i].st, s[i].op, s[i].z, s[i].mr, s[i].r));
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL lw cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_stall();
    stim_t s[$] = '{'{1'b0, RT, 1'b0, 1'b0, 4'd0}, '{1'b0, RT, 1'b0, 1'b0, 4'd0},
                    '{1'b0, RT, 1'b0, 1'b0, 4'd0}, '{1'b0, RT, 1'b0, 1'b1, 4'd0},
                    '{1'b0, RT, 1'b1, 1'b0, 4'd1}, '{1'b0, RT, 1'b1, 1'b1, 4'd6},
                    '{1'b0, RT, 1'b1, 1'b0, 4'd7}};
    foreach (s[i]) begin
      {rst, opcode, zero, mem_ready} = {s[i].r, s[i].op, s[i].z, s[i].mr};
      sb.push_back(exp_out(s[i].st, s[i].op, s[i].z, s[i].mr, s[i].r));
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL rtype cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    stim_t s[$] = '{'{1'b0, BEQ, 1'b0, 1'b1, 4'd0}, '{1'b0, BEQ, 1'b1, 1'b1, 4'd1},
                    '{1'b0, BEQ, 1'b1, 1'b1, 4'd8}, '{1'b0, BEQ, 1'b1, 1'b1, 4'd0},
                    '{1'b0, BEQ, 1'b1, 1'b0, 4'd1}, '{1'b0, BEQ, 1'b0, 1'b1, 4'd8}};
    foreach (s[i]) begin
      {rst, opcode, zero, mem_ready} = {s[i].r, s[i].op, s[i].z, s[i].mr};
      sb.push_back(exp_out(s[i].st, s[i].op, s[i].z, s[i].mr, s[i].r));
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL beq cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    stim_t s[$] = '{'{1'b0, SW, 1'b1, 1'b1, 4'd0}, '{1'b0, SW, 1'b1, 1'b1, 4'd1},
                    '{1'b0, SW, 1'b1, 1'b1, 4'd2}, '{1'b0, SW, 1'b1, 1'b0, 4'd5},
                    '{1'b0, SW, 1'b1, 1'b0, 4'd5}, '{1'b0, SW, 1'b1, 1'b1, 4'd5},
                    '{1'b0, SW, 1'b1, 1'b0, 4'd0}};
    foreach (s[i]) begin
      {rst, opcode, zero, mem_ready} = {s[i].r, s[i].op, s[i].z, s[i].mr};
      sb.push_back(exp_out(s[i].st, s[i].op, s[i].z, s[i].mr, s[i].r));
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL sw cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_and_jump();
    stim_t s[$] = '{'{1'b0, BAD, 1'b1, 1'b1, 4'd0}, '{1'b0, BAD, 1'b1, 1'b1, 4'd1},
                    '{1'b0, BAD, 1'b1, 1'b0, 4'd0}, '{1'b0, J, 1'b0, 1'b1, 4'd0},
                    '{1'b0, J, 1'b0, 1'b0, 4'd1}, '{1'b0, J, 1'b0, 1'b0, 4'd11},
                    '{1'b0, J, 1'b0, 1'b0, 4'd0}};
    foreach (s[i]) begin
      {rst, opcode, zero, mem_ready} = {s[i].r, s[i].op, s[i].z, s[i].mr};
      sb.push_back(exp_out(s[i].st, s[i].op, s[i].z, s[i].mr, s[i].r));
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL illegal_j cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
    stim_t s[$] = '{'{1'b0, ADDI, 1'b0, 1'b1, 4'd0}, '{1'b0, ADDI, 1'b1, 1'b1, 4'd1},
                    '{1'b0, ADDI, 1'b1, 1'b1, 4'd9}, '{1'b0, ADDI, 1'b1, 1'b1, 4'd10}};
    foreach (s[i]) begin
      {rst, opcode, zero, mem_ready} = {s[i].r, s[i].op, s[i].z, s[i].mr};
      sb.push_back(exp_out(s[i].st, s[i].op, s[i].z, s[i].mr, s[i].r));
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL addi cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_memwr();
    stim_t s[$] = '{'{1'b0, SW, 1'b0, 1'b1, 4'd0}, '{1'b0, SW, 1'b0, 1'b1, 4'd1},
                    '{1'b0, SW, 1'b0, 1'b1, 4'd2}, '{1'b1, SW, 1'b0, 1'b0, 4'd5},
                    '{1'b0, SW, 1'b0, 1'b1, 4'd0}, '{1'b0, SW, 1'b0, 1'b1, 4'd1},
                    '{1'b0, SW, 1'b0, 1'b1, 4'd2}, '{1'b0, SW, 1'b0, 1'b1, 4'd5},
                    '{1'b0, SW, 1'b0, 1'b0, 4'd0}};
    foreach (s[i]) begin
      {rst, opcode, zero, mem_ready} = {s[i].r, s[i].op, s[i].z, s[i].mr};
      sb.push_back(exp_out(s[i].st, s[i].op, s[i].z, s[i].mr, s[i].r));
      @(negedge clk);
      want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL rst_memwr cyc%0d got=%h want=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_stall();
    test_beq();
    test_sw_stall();
    test_illegal_and_jump();
    test_addi();
    test_reset_mid_memwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
